prbs7_parity_checker: RTL

- Receive-side checker for the 8-bit PRBS7-plus-parity word stream produced by the team's LFSR generator.
- Word format: din[6:0] is the LFSR state, polynomial x^7+x^6+1. The next state is next(s) = {s[5:0], s[6]^s[5]}. din[7] = ~^din[6:0], so a good word has an odd number of ones.
- The block hunts for sequence alignment, locks, then flywheels its own reference LFSR.
- It flags and counts parity and sequence errors for link bring-up and BIST.

---
 rtl/prbs7_parity_checker.sv | 119 +++++++++++
 1 files changed

// File: rtl/prbs7_parity_checker.sv
// Receive-side checker for the PRBS7 (x^7+x^6+1) plus odd-parity word stream.
// Define PRBS_LOSS_RELOCK_EN to drop lock after LOSS_COUNT consecutive sequence misses.
module prbs7_parity_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             par_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] par_err_cnt,
  output logic [CNT_W-1:0] seq_err_cnt
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [6:0]       expected_q, expected_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             par_d, seq_d;
  logic [CNT_W-1:0] pcnt_d, scnt_d;
  logic             parity_ok, word_ok, data_ok;

  function automatic logic [6:0] next7(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  assign parity_ok = ^din;
  assign word_ok   = parity_ok && (din[6:0] != 7'd0);
  assign data_ok   = (din[6:0] == expected_q);

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    match_d    = match_q;
    miss_d     = miss_q;
    par_d      = 1'b0;
    seq_d      = 1'b0;
    pcnt_d     = par_err_cnt;
    scnt_d     = seq_err_cnt;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (!word_ok) begin
            match_d = 4'd0;
          end else begin
            expected_d = next7(din[6:0]);
            if (match_q != 4'd0 && data_ok) match_d = match_q + 4'd1;
            else                            match_d = 4'd1;
            if (match_d == 4'(LOCK_COUNT)) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: the reference never reseeds from received data.
          expected_d = next7(expected_q);
          if (!parity_ok) begin
            par_d = 1'b1;
            if (par_err_cnt != '1) pcnt_d = par_err_cnt + CNT_W'(1);
          end
          if (!data_ok) begin
            seq_d = 1'b1;
            if (seq_err_cnt != '1) scnt_d = seq_err_cnt + CNT_W'(1);
            if (miss_q < 4'(LOSS_COUNT)) miss_d = miss_q + 4'd1;
          end else begin
            miss_d = 4'd0;
          end
`ifdef PRBS_LOSS_RELOCK_EN
          if (miss_d == 4'(LOSS_COUNT)) begin
            state_d = HUNT;
            match_d = 4'd0;
            miss_d  = 4'd0;
          end
`endif
        end
        default: state_d = HUNT;
      endcase
    end

    if (cnt_clr) begin
      pcnt_d = '0;
      scnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      expected_q  <= 7'd0;
      match_q     <= 4'd0;
      miss_q      <= 4'd0;
      par_err     <= 1'b0;
      seq_err     <= 1'b0;
      par_err_cnt <= '0;
      seq_err_cnt <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      par_err     <= par_d;
      seq_err     <= seq_d;
      par_err_cnt <= pcnt_d;
      seq_err_cnt <= scnt_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule
